uart_rx_fifo: RTL and testbench

- Hardware UART receiver for the serial RX pin, presented to the system as a byte source with a small FIFO.
- Replaces software bit-banged reception on the RX gpio line; the pin is sampled directly.
- Format fixed at 8N1: 8 data bits, LSB first, no parity, 1 stop bit.
- Flags framing errors and overruns as sticky status bits.

---
 rtl/uart_rx_fifo.sv | 180 ++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver: two-flop rx synchroniser, mid-bit sampling FSM and a small byte FIFO
// with sticky framing-error and overrun flags.
module uart_rx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 208,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       power_on_reset,
  input  logic       rx,
  input  logic       rd,
  output logic [7:0] data,
  output logic       valid,
  output logic       framing_error,
  output logic       overrun,
  input  logic       clr_err
);

  localparam int unsigned CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned FCNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0]  HALF_RELOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]  BIT_RELOAD  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [FCNT_W-1:0] DEPTH_C     = FCNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_e;

  logic                           rx_meta_q, rxs_q;
  state_e                         state_q, state_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [2:0]                     bit_idx_q, bit_idx_d;
  logic [7:0]                     shift_q, shift_d;
  logic [FIFO_DEPTH-1:0][7:0]     mem_q, mem_d;
  logic [PTR_W-1:0]               wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]               rd_ptr_q, rd_ptr_d;
  logic [FCNT_W-1:0]              count_q, count_d;
  logic                           fe_q, fe_d;
  logic                           ov_q, ov_d;

  logic stop_ok;
  logic fe_set;
  logic full;
  logic pop;
  logic push;
  logic ov_set;

  // State registers, including the rx synchroniser (resets to idle-high)
  always_ff @(posedge clk) begin
    if (power_on_reset) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      mem_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      fe_q      <= 1'b0;
      ov_q      <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rxs_q     <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      fe_q      <= fe_d;
      ov_q      <= ov_d;
    end
  end

  // Receive FSM: every decision is taken when the baud counter hits zero (mid-bit)
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    stop_ok   = 1'b0;
    fe_set    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!rxs_q) begin
          state_d = S_START;
          cnt_d   = HALF_RELOAD;
        end
      end
      S_START: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (rxs_q) begin
          state_d = S_IDLE;
        end else begin
          state_d   = S_DATA;
          bit_idx_d = '0;
          cnt_d     = BIT_RELOAD;
        end
      end
      S_DATA: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          shift_d   = {rxs_q, shift_q[7:1]};
          cnt_d     = BIT_RELOAD;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (rxs_q) begin
          stop_ok = 1'b1;
          state_d = S_IDLE;
        end else begin
          fe_set  = 1'b1;
          state_d = S_BREAK;
        end
      end
      S_BREAK: begin
        // Hold here while the line stays low so a break yields one error, not many frames
        if (rxs_q) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FIFO: a same-cycle pop frees the slot a push into a full buffer needs
  always_comb begin
    full     = (count_q == DEPTH_C);
    pop      = rd && (count_q != '0);
    push     = stop_ok && (!full || pop);
    ov_set   = stop_ok && full && !pop;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = shift_q;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push && !pop) begin
      count_d = count_q + FCNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - FCNT_W'(1);
    end
  end

  // Sticky flags: a set event in the same cycle as clr_err wins
  always_comb begin
    fe_d = fe_set || (fe_q && !clr_err);
    ov_d = ov_set || (ov_q && !clr_err);
  end

  assign data          = mem_q[rd_ptr_q];
  assign valid         = (count_q != '0);
  assign framing_error = fe_q;
  assign overrun       = ov_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed corner sequences, a frame table and randomized frames
// checked against a frame-level queue model.
module tb_uart_rx_fifo;

  localparam int unsigned CPB   = 8;
  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       power_on_reset = 1'b1;
  logic       rx = 1'b1;
  logic       rd = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic       framing_error;
  logic       overrun;

  int checks   = 0;
  int failures = 0;

  logic [7:0] mq[$];
  logic       mfe;
  logic       mov;

  typedef struct {
    logic [7:0] byte_v;
    logic       stop_v;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_fe;
    logic       exp_ov;
  } vec_t;

  vec_t vecs[6];

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .power_on_reset (power_on_reset),
    .rx             (rx),
    .rd             (rd),
    .data           (data),
    .valid          (valid),
    .framing_error  (framing_error),
    .overrun        (overrun),
    .clr_err        (clr_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    power_on_reset = 1'b1;
    rx = 1'b1;
    rd = 1'b0;
    clr_err = 1'b0;
    repeat (2) tick();
    power_on_reset = 1'b0;
    tick();
  endtask

  // Drives start + 8 data bits, leaves the stop bit on the line; returns 72 edges after start
  task automatic drive_bits(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) tick();
    end
    rx = stop_bit;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    drive_bits(b, stop_bit);
    repeat (CPB) tick();
    rx = 1'b1;
    repeat (4) tick();
  endtask

  task automatic pop_check(input string name, input logic [7:0] exp);
    check({name, " valid"}, 32'(valid), 32'(1));
    check({name, " data"}, 32'(data), 32'(exp));
    rd = 1'b1;
    tick();
    rd = 1'b0;
  endtask

  task automatic cmp_model(input string tag);
    check({tag, " valid"}, 32'(valid), 32'(mq.size() != 0));
    if (mq.size() != 0) check({tag, " data"}, 32'(data), 32'(mq[0]));
    check({tag, " fe"}, 32'(framing_error), 32'(mfe));
    check({tag, " ov"}, 32'(overrun), 32'(mov));
  endtask

  initial begin
    vecs[0] = '{8'h01, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[1] = '{8'h02, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[2] = '{8'h03, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[3] = '{8'h04, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[4] = '{8'h05, 1'b1, 1'b1, 8'h01, 1'b0, 1'b1};
    vecs[5] = '{8'h77, 1'b0, 1'b1, 8'h01, 1'b1, 1'b1};

    // Reset state
    do_reset();
    check("reset valid", 32'(valid), 32'(0));
    check("reset data", 32'(data), 32'(0));
    check("reset fe", 32'(framing_error), 32'(0));
    check("reset ov", 32'(overrun), 32'(0));

    // 0xA5 with exact push timing: stop sample lands 79 edges after the start bit begins
    drive_bits(8'hA5, 1'b1);
    repeat (6) tick();
    check("a5 valid before stop sample", 32'(valid), 32'(0));
    tick();
    check("a5 valid after stop sample", 32'(valid), 32'(1));
    check("a5 data", 32'(data), 32'(8'hA5));
    tick();
    rx = 1'b1;
    repeat (4) tick();
    pop_check("a5 pop", 8'hA5);
    check("a5 valid after pop", 32'(valid), 32'(0));
    check("a5 fe", 32'(framing_error), 32'(0));
    check("a5 ov", 32'(overrun), 32'(0));

    // Short low glitch is a false start
    rx = 1'b0;
    repeat (3) tick();
    rx = 1'b1;
    repeat (12) tick();
    check("glitch valid", 32'(valid), 32'(0));
    check("glitch fe", 32'(framing_error), 32'(0));
    send_frame(8'h3C, 1'b1);
    pop_check("3c pop", 8'h3C);

    // Bad stop bit followed by a held-low line: one error only
    drive_bits(8'h55, 1'b0);
    repeat (CPB) tick();
    check("break fe set", 32'(framing_error), 32'(1));
    check("break no push", 32'(valid), 32'(0));
    repeat (10) tick();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    repeat (29) tick();
    check("break no second error", 32'(framing_error), 32'(0));
    rx = 1'b1;
    repeat (10) tick();
    check("break fe after release", 32'(framing_error), 32'(0));
    check("break valid after release", 32'(valid), 32'(0));
    send_frame(8'h12, 1'b1);
    pop_check("12 pop", 8'h12);

    // Framing error coinciding with clr_err: set wins, then clr_err clears
    drive_bits(8'h00, 1'b0);
    repeat (6) tick();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("fe set beats clr", 32'(framing_error), 32'(1));
    tick();
    rx = 1'b1;
    repeat (6) tick();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("fe cleared", 32'(framing_error), 32'(0));

    // Frame table: fill past capacity, then a framing error with the FIFO full
    do_reset();
    foreach (vecs[i]) begin
      send_frame(vecs[i].byte_v, vecs[i].stop_v);
      check($sformatf("vec%0d valid", i), 32'(valid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d data", i), 32'(data), 32'(vecs[i].exp_data));
      check($sformatf("vec%0d fe", i), 32'(framing_error), 32'(vecs[i].exp_fe));
      check($sformatf("vec%0d ov", i), 32'(overrun), 32'(vecs[i].exp_ov));
    end
    for (int i = 1; i <= 4; i++) pop_check($sformatf("ovr pop%0d", i), 8'(i));
    check("ovr drained", 32'(valid), 32'(0));

    // Full FIFO, pop on the push cycle: accepted, no overrun
    do_reset();
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1);
    drive_bits(8'h05, 1'b1);
    repeat (6) tick();
    rd = 1'b1;
    tick();
    rd = 1'b0;
    check("full pushpop ov", 32'(overrun), 32'(0));
    tick();
    rx = 1'b1;
    repeat (4) tick();
    for (int i = 2; i <= 5; i++) pop_check($sformatf("full pushpop pop%0d", i), 8'(i));
    check("full pushpop drained", 32'(valid), 32'(0));
    check("full pushpop ov end", 32'(overrun), 32'(0));

    // Empty FIFO, pop on the push cycle: pop ignored, byte kept
    drive_bits(8'h6A, 1'b1);
    repeat (6) tick();
    rd = 1'b1;
    tick();
    rd = 1'b0;
    check("empty pushpop valid", 32'(valid), 32'(1));
    check("empty pushpop data", 32'(data), 32'(8'h6A));
    tick();
    rx = 1'b1;
    repeat (4) tick();
    pop_check("empty pushpop pop", 8'h6A);
    check("empty pushpop drained", 32'(valid), 32'(0));

    // Reset in the middle of a 0xFF frame
    rx = 1'b0;
    repeat (CPB) tick();
    rx = 1'b1;
    repeat (20) tick();
    power_on_reset = 1'b1;
    repeat (2) tick();
    power_on_reset = 1'b0;
    repeat (80) tick();
    check("midreset valid", 32'(valid), 32'(0));
    check("midreset fe", 32'(framing_error), 32'(0));
    check("midreset ov", 32'(overrun), 32'(0));
    send_frame(8'h81, 1'b1);
    pop_check("81 pop", 8'h81);

    // Randomized frames, pops and clears against a frame-level queue model
    do_reset();
    mq.delete();
    mfe = 1'b0;
    mov = 1'b0;
    for (int n = 0; n < 40; n++) begin
      logic [7:0] b;
      logic       s;
      int         k;
      b = 8'($urandom);
      s = ($urandom_range(0, 7) != 0);
      send_frame(b, s);
      if (!s) mfe = 1'b1;
      else if (mq.size() < DEPTH) mq.push_back(b);
      else mov = 1'b1;
      cmp_model($sformatf("rnd%0d frame", n));
      k = int'($urandom_range(0, 2));
      for (int p = 0; p < k; p++) begin
        rd = 1'b1;
        tick();
        rd = 1'b0;
        if (mq.size() != 0) void'(mq.pop_front());
        cmp_model($sformatf("rnd%0d pop%0d", n, p));
      end
      if ($urandom_range(0, 5) == 0) begin
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        mfe = 1'b0;
        mov = 1'b0;
        cmp_model($sformatf("rnd%0d clr", n));
      end
      repeat (int'($urandom_range(0, 5))) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
